// File: rtl/viterbi_pkg.sv
// Shared types and helpers for the Viterbi BER test controller.
package viterbi_pkg;

  typedef enum logic [2:0] {IDLE, RUN, FLUSH, DRAIN, DONE} state_t;

  // PRBS7 x^7 + x^6 + 1, output taken from bit 6
  localparam logic [6:0] PRBS_SEED  = 7'h7F;
  localparam int         PRBS_TAP_A = 6;
  localparam int         PRBS_TAP_B = 5;

  function automatic logic [1:0] popcount2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/viterbi_err_inj.sv
// Periodic burst error injector between the encoder output and the decoder input.
module viterbi_err_inj
  import viterbi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic [7:0] i_period,
  input  logic [7:0] i_burst,
  input  logic [1:0] i_mask,
  input  logic       i_valid,
  input  logic [1:0] i_sym,
  output logic       o_valid,
  output logic [1:0] o_sym,
  output logic       o_inj
);

  logic [7:0] r_phase;

  assign o_inj = i_valid && (i_period != 8'd0) && (r_phase < i_burst);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase <= '0;
      o_valid <= 1'b0;
      o_sym   <= '0;
    end else begin
      o_valid <= i_valid;
      o_sym   <= i_sym ^ (o_inj ? i_mask : 2'b00);
      if (i_clr)
        r_phase <= '0;
      else if (i_valid)
        r_phase <= (i_period == 8'd0 || r_phase == i_period - 8'd1) ? 8'd0 : r_phase + 8'd1;
    end
  end

endmodule

// File: rtl/viterbi_ber_ctrl.sv
// Test sequencer: PRBS frame + zero tail into the encoder, burst errors into the
// decoder path, and bit-error counting against the delayed source bits.
module viterbi_ber_ctrl
  import viterbi_pkg::*;
#(
  parameter int K       = 3,
  parameter int DEC_LAT = 16,
  parameter int LEN_W   = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic [7:0]       err_period,
  input  logic [7:0]       err_burst,
  input  logic [1:0]       err_mask,
  output logic             enc_en_o,
  output logic             enc_bit_o,
  input  logic             enc_valid_i,
  input  logic [1:0]       enc_sym_i,
  output logic             dec_en_o,
  output logic [1:0]       dec_sym_o,
  input  logic             dec_bit_i,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sym_err_ct,
  output logic [CNT_W-1:0] bit_err_ct,
  output logic [CNT_W-1:0] bits_checked
);

  localparam int TAIL   = K - 1;
  localparam int PIPE_D = 2 + DEC_LAT;
  localparam int CW     = (LEN_W > $clog2(PIPE_D + TAIL + 1)) ? LEN_W : $clog2(PIPE_D + TAIL + 1);

  state_t                   r_state, w_nxt;
  logic                     w_acc;
  logic [CW-1:0]            r_cnt;
  logic [LEN_W-1:0]         r_len;
  logic [7:0]               r_period, r_burst;
  logic [1:0]               r_mask;
  logic [6:0]               r_lfsr;
  logic [PIPE_D-1:0][1:0]   r_pipe;
  logic [1:0]               w_tap;
  logic                     w_inj;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  always_comb begin
    w_nxt = r_state;
    w_acc = 1'b0;
    case (r_state)
      IDLE:  if (start) begin
               w_acc = 1'b1;
               w_nxt = (frame_len == '0) ? FLUSH : RUN;
             end
      RUN:   if (r_cnt == CW'(r_len - 1'b1)) w_nxt = FLUSH;
      FLUSH: if (r_cnt == CW'(TAIL - 1))     w_nxt = DRAIN;
      DRAIN: if (r_cnt == CW'(PIPE_D - 1))   w_nxt = DONE;
      DONE:  w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  assign enc_en_o  = (r_state == RUN) || (r_state == FLUSH);
  assign enc_bit_o = (r_state == RUN) && r_lfsr[PRBS_TAP_A];
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign w_tap     = r_pipe[PIPE_D-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_len    <= '0;
      r_period <= '0;
      r_burst  <= '0;
      r_mask   <= '0;
      r_lfsr   <= PRBS_SEED;
      r_pipe   <= '0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= (w_nxt != r_state) ? '0 : r_cnt + 1'b1;
      // {is_data, bit} per cycle; lines up with dec_bit_i at the tap
      r_pipe  <= {r_pipe[PIPE_D-2:0], {r_state == RUN, enc_bit_o}};
      if (w_acc) begin
        r_len    <= frame_len;
        r_period <= err_period;
        r_burst  <= err_burst;
        r_mask   <= err_mask;
        r_lfsr   <= PRBS_SEED;
      end else if (r_state == RUN) begin
        r_lfsr <= {r_lfsr[5:0], r_lfsr[PRBS_TAP_A] ^ r_lfsr[PRBS_TAP_B]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sym_err_ct   <= '0;
      bit_err_ct   <= '0;
      bits_checked <= '0;
    end else if (w_acc) begin
      sym_err_ct   <= '0;
      bit_err_ct   <= '0;
      bits_checked <= '0;
    end else begin
      if (w_inj)
        sym_err_ct <= sat_add(sym_err_ct, popcount2(r_mask));
      if (w_tap[1]) begin
        bits_checked <= sat_add(bits_checked, 2'd1);
        if (dec_bit_i != w_tap[0])
          bit_err_ct <= sat_add(bit_err_ct, 2'd1);
      end
    end
  end

  viterbi_err_inj u_inj (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_acc),
    .i_period (r_period),
    .i_burst  (r_burst),
    .i_mask   (r_mask),
    .i_valid  (enc_valid_i),
    .i_sym    (enc_sym_i),
    .o_valid  (dec_en_o),
    .o_sym    (dec_sym_o),
    .o_inj    (w_inj)
  );

endmodule

// File: tb/tb_viterbi_ber_ctrl.sv
// Bench: rate-1/2 K=3 encoder and a simple inverting decoder around the controller,
// with a queue of expected per-frame results checked when done pulses.
module tb_viterbi_ber_ctrl;

  localparam int K = 3, DEC_LAT = 16, LEN_W = 16, CNT_W = 16;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [LEN_W-1:0] frame_len = '0;
  logic [7:0] err_period = '0, err_burst = '0;
  logic [1:0] err_mask = '0;
  logic enc_en_o, enc_bit_o, enc_valid_i, dec_en_o, dec_bit_i, busy, done;
  logic [1:0] enc_sym_i, dec_sym_o;
  logic [CNT_W-1:0] sym_err_ct, bit_err_ct, bits_checked;
  logic enc_en4, enc_bit4, dec_en4, busy4, done4;
  logic [1:0] dec_sym4;
  logic [3:0] sym4, bit4, chk4;

  typedef struct { int sym_err; int bit_err; int nchk; int done_cyc; } exp_t;
  exp_t q[$];
  exp_t mon_e;
  int checks = 0, errors = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  viterbi_ber_ctrl #(.K(K), .DEC_LAT(DEC_LAT), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .frame_len(frame_len), .err_period(err_period),
    .err_burst(err_burst), .err_mask(err_mask), .enc_en_o(enc_en_o), .enc_bit_o(enc_bit_o),
    .enc_valid_i(enc_valid_i), .enc_sym_i(enc_sym_i), .dec_en_o(dec_en_o), .dec_sym_o(dec_sym_o),
    .dec_bit_i(dec_bit_i), .busy(busy), .done(done), .sym_err_ct(sym_err_ct),
    .bit_err_ct(bit_err_ct), .bits_checked(bits_checked));

  // Narrow-counter copy sharing the same channel; its datapath is identical
  viterbi_ber_ctrl #(.K(K), .DEC_LAT(DEC_LAT), .LEN_W(LEN_W), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .frame_len(frame_len), .err_period(err_period),
    .err_burst(err_burst), .err_mask(err_mask), .enc_en_o(enc_en4), .enc_bit_o(enc_bit4),
    .enc_valid_i(enc_valid_i), .enc_sym_i(enc_sym_i), .dec_en_o(dec_en4), .dec_sym_o(dec_sym4),
    .dec_bit_i(dec_bit_i), .busy(busy4), .done(done4), .sym_err_ct(sym4),
    .bit_err_ct(bit4), .bits_checked(chk4));

  // Encoder g1=101 (sym[1]), g0=111 (sym[0])
  logic es1, es2;
  always @(posedge clk or negedge rst)
    if (!rst) begin
      enc_valid_i <= 1'b0; enc_sym_i <= 2'b00; es1 <= 1'b0; es2 <= 1'b0;
    end else begin
      enc_valid_i <= enc_en_o;
      if (enc_en_o) begin
        enc_sym_i <= {enc_bit_o ^ es2, enc_bit_o ^ es1 ^ es2};
        es2 <= es1; es1 <= enc_bit_o;
      end
    end

  // Decoder: inverts the g1 stream, DEC_LAT cycles of latency
  logic dd1, dd2, dbit;
  logic [DEC_LAT-1:0] dline;
  assign dbit      = dec_sym_o[1] ^ dd2;
  assign dec_bit_i = dline[DEC_LAT-1];
  always @(posedge clk or negedge rst)
    if (!rst) begin
      dd1 <= 1'b0; dd2 <= 1'b0; dline <= '0;
    end else begin
      dline <= {dline[DEC_LAT-2:0], dec_en_o & dbit};
      if (start && !busy) begin
        dd1 <= 1'b0; dd2 <= 1'b0;
      end else if (dec_en_o) begin
        dd2 <= dd1; dd1 <= dbit;
      end
    end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic exp_t model(input int L, input int per, input int bur, input logic [1:0] m);
    int a[$];
    int src[$];
    int b, b1, b2, d, d1, d2, s1;
    exp_t e;
    e = '{0, 0, 0, 0};
    for (int n = 0; n < L; n++) a.push_back(n < 7 ? 1 : (a[n-7] ^ a[n-6]));
    src = a;
    for (int n = 0; n < K - 1; n++) src.push_back(0);
    b1 = 0; b2 = 0; d1 = 0; d2 = 0;
    for (int n = 0; n < src.size(); n++) begin
      b  = src[n];
      s1 = b ^ b2;
      if (per != 0 && (n % per) < bur) begin
        s1 = s1 ^ int'(m[1]);
        e.sym_err += int'(m[0]) + int'(m[1]);
      end
      d = s1 ^ d2;
      if (n < L && d != b) e.bit_err++;
      b2 = b1; b1 = b; d2 = d1; d1 = d;
    end
    e.nchk = L;
    return e;
  endfunction

  task automatic run(input int L, input int per, input int bur, input logic [1:0] m);
    exp_t e;
    @(posedge clk); #1;
    frame_len = LEN_W'(L); err_period = 8'(per); err_burst = 8'(bur); err_mask = m;
    start = 1'b1;
    e = model(L, per, bur, m);
    e.done_cyc = cyc + L + (K - 1) + (2 + DEC_LAT) + 1;
    q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (q.size() != 0 && n < 500) begin @(posedge clk); n++; end
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: %0d frames pending, required 0", q.size());
      q.delete();
    end
    repeat (3) @(posedge clk); #1;
    chk("idle_busy", busy, 0);
  endtask

  always @(negedge clk) if (rst && done) begin
    if (q.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_done: done=1 at cycle %0d, required no frame pending", cyc);
    end else begin
      mon_e = q.pop_front();
      chk("done_cycle",   cyc,          mon_e.done_cyc);
      chk("sym_err_ct",   sym_err_ct,   sat(mon_e.sym_err, 65535));
      chk("bit_err_ct",   bit_err_ct,   sat(mon_e.bit_err, 65535));
      chk("bits_checked", bits_checked, sat(mon_e.nchk, 65535));
      chk("done4",        done4,        1);
      chk("sym_err_ct4",  sym4,         sat(mon_e.sym_err, 15));
      chk("bit_err_ct4",  bit4,         sat(mon_e.bit_err, 15));
      chk("bits_checked4", chk4,        sat(mon_e.nchk, 15));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_enc_en", enc_en_o, 0);
    chk("rst_counters", int'(sym_err_ct) + int'(bit_err_ct) + int'(bits_checked), 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    run(32, 0, 0, 2'b00);  wait_done();
    run(64, 16, 1, 2'b01); wait_done();
    run(64, 8, 4, 2'b11);  wait_done();
    run(32, 1, 1, 2'b11);  wait_done();

    // Zero-length frame with a start attempt while busy
    run(0, 0, 0, 2'b00);
    repeat (3) @(posedge clk); #1;
    frame_len = 16'd50; err_period = 8'd1; err_burst = 8'd1; err_mask = 2'b11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
    repeat (30) @(posedge clk); #1;
    chk("busy_start_ignored", busy, 0);

    // Abort mid-run
    @(posedge clk); #1;
    frame_len = 16'd32; err_period = 8'd1; err_burst = 8'd1; err_mask = 2'b11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk); #1;
    chk("pre_rst_sym_err", sym_err_ct, 16);
    rst = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_enc_en", enc_en_o, 0);
    chk("abort_enc_bit", enc_bit_o, 0);
    chk("abort_dec_en", dec_en_o, 0);
    chk("abort_dec_sym", dec_sym_o, 0);
    chk("abort_sym_err", sym_err_ct, 0);
    chk("abort_bits_checked", bits_checked, 0);
    repeat (2) @(posedge clk); #1;
    rst = 1'b1;
    repeat (40) @(posedge clk);
    run(32, 0, 0, 2'b00);  wait_done();

    for (int i = 0; i < 8; i++) begin
      int L, per, bur;
      L   = $urandom_range(80, 0);
      per = $urandom_range(12, 0);
      bur = $urandom_range(per + 2, 0);
      run(L, per, bur, 2'($urandom_range(3, 0)));
      wait_done();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
